record_mode: RTL
================

# record_mode

Keyboard recording front end that fills the song buffer consumed by play mode. While recording, it samples the eight note keys and the octave-shift inputs once per note period. Each sample is packed into a 10-bit frame and written to the buffer through a valid/ready write port. Frame layout is identical to what play mode reads back, so a recorded song replays at the same tempo.

## Interface
Parameters:
- PERIOD, 100000: clk cycles per frame (note period); minimum 4.
- MAX_FRAMES, 4096: frame capacity of the song buffer; recording ends when reached.
- CNT_W, 20: width of the period counter; must hold PERIOD-1.

Ports:
- clk  in  1  single system clock; all logic on posedge.
- rst_n  in  1  reset, asynchronous, active-low.
- rec_start  in  1  one-cycle pulse; starts a recording when idle.
- rec_stop  in  1  one-cycle pulse; ends the recording.
- keys  in  8  raw note keys, bit0 = low C … bit7 = high C; asynchronous.
- shift  in  2  raw octave shift; asynchronous.
- wr_ready  in  1  buffer can accept a frame this cycle.
- wr_en  out  1  frame valid on wr_data.
- wr_data  out  10  {keys[7:0], shift[1:0]}; bits 9:2 notes, bits 1:0 shift.
- busy  out  1  high in any state other than IDLE.
- frame_count  out  16  frames accepted by the buffer in the current recording.
- overflow  out  1  sticky: a frame was dropped because the previous one was still pending.

## Operation
- keys and shift pass through a 2-flop synchronizer; sampled values lag the pins by 2 cycles.
- States: IDLE, ARMED, RECORD, FLUSH.
- IDLE:
  - rec_start → ARMED; clears frame_count, overflow, period counter, pending.
  - rec_start and rec_stop in the same cycle: stop wins, stay IDLE.
- ARMED: trims leading silence.
  - First cycle with synced keys ≠ 0 → RECORD; that cycle's sample becomes frame 0 (pending next cycle); period counter restarts at 0.
  - rec_stop → IDLE with no frames written.
- RECORD:
  - Period counter counts 0..PERIOD-1 and wraps; tick when count == PERIOD-1.
  - Each tick: if no frame is pending, the synced sample becomes pending; otherwise the sample is dropped and overflow is set.
  - rec_stop → FLUSH.
  - frame_count + (pending ? 1 : 0) == MAX_FRAMES → FLUSH; no further frames are captured.
- FLUSH: waits until no frame is pending, then → IDLE.
- Write handshake:
  - wr_en = pending.
  - A transfer occurs on a cycle with wr_en & wr_ready; pending clears and frame_count increments on that edge.
  - wr_data is held stable while wr_en is high.
  - A frame is never written twice and never modified while pending.
- frame_count saturates at MAX_FRAMES and holds its value in IDLE until the next rec_start.
- rec_start outside IDLE is ignored.
- rec_stop in IDLE or FLUSH is ignored.

## Timing
- Reset values: wr_en 0, wr_data 0, busy 0, frame_count 0, overflow 0, state IDLE, counter 0, synchronizer flops 0.
- busy rises the cycle after the rec_start edge.
- ARMED → RECORD: frame 0 becomes pending (wr_en high) 1 cycle after the first nonzero synced keys, i.e. 3 cycles after the pin change.
- Subsequent frames go pending 1 cycle after each tick, spaced exactly PERIOD cycles.
- With wr_ready tied high, each frame is accepted in the cycle wr_en rises.
- Tick coinciding with a transfer cycle: the transfer frees the slot on that same edge, so the new sample is accepted and no overflow occurs.
- rec_stop on the same cycle as a tick: the tick's frame is captured, then the block enters FLUSH.
- rst_n low mid-recording: returns immediately to reset values. A pending frame is lost, and the buffer must tolerate wr_en dropping without a transfer.

## Structure
- Shared package music_pkg:
  - FRAME_W = 10; NOTE_LSB = 2; SHIFT_W = 2.
  - rec_state_t enum {IDLE, ARMED, RECORD, FLUSH}.
  - Play mode uses the same package for frame unpacking.
- One sub-module: key_sync, a parameterised-width 2-flop synchronizer, instantiated once on {keys, shift}.
- Period counter, FSM and pending register live in record_mode.

## Test plan
All scenarios use PERIOD=8, MAX_FRAMES=4.
- Reset then idle: all outputs 0. rec_start with keys=0 → busy=1, no wr_en for 50 cycles; rec_stop → busy=0, frame_count=0.
- keys=8'h01, shift=2'b10 with wr_ready=1 after rec_start → wr_data=10'h006 accepted; following frames exactly 8 cycles apart; rec_stop after 3 frames → frame_count=3, busy falls.
- keys=8'h80 held, wr_ready=1 → 4 frames of 10'h200, auto FLUSH → IDLE, frame_count=4, no fifth wr_en.
- wr_ready=0 for 20 cycles during RECORD → wr_en and wr_data held stable, overflow=1 after the second tick. On wr_ready=1, exactly one transfer of the held frame.
- rst_n pulsed low while wr_en=1 → wr_en=0 immediately, state IDLE, frame_count=0, overflow=0.
- rec_start and rec_stop in the same cycle in IDLE → busy stays 0. rec_start while RECORD → no effect on frame_count or cadence.

Source files
------------

// File: rtl/music_pkg.sv
// Shared definitions for the song buffer frame format and the recorder state machine.
// Play mode imports the same package to unpack frames.
package music_pkg;

  localparam int FRAME_W  = 10;
  localparam int NOTE_W   = 8;
  localparam int NOTE_LSB = 2;
  localparam int SHIFT_W  = 2;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ARMED  = 2'd1,
    RECORD = 2'd2,
    FLUSH  = 2'd3
  } rec_state_t;

  function automatic logic [FRAME_W-1:0] pack_frame(
    input logic [NOTE_W-1:0]  notes,
    input logic [SHIFT_W-1:0] shift
  );
    return {notes, shift};
  endfunction

endpackage

// File: rtl/key_sync.sv
// Parameterised-width two-flop synchronizer for asynchronous key inputs.
module key_sync #(
  parameter int WIDTH = 10
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta_q;
  logic [WIDTH-1:0] sync_q;

  // NOTE: sequential state uses non-blocking assignments so both stages
  // shift together on the same edge instead of collapsing into one flop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/record_mode.sv
// Keyboard recorder: samples synced keys/shift once per note period and
// writes packed frames to the song buffer over a valid/ready port.
module record_mode
  import music_pkg::*;
#(
  parameter int PERIOD     = 100000,
  parameter int MAX_FRAMES = 4096,
  parameter int CNT_W      = 20
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         rec_start,
  input  logic         rec_stop,
  input  logic [7:0]   keys,
  input  logic [1:0]   shift,
  input  logic         wr_ready,
  output logic         wr_en,
  output logic [9:0]   wr_data,
  output logic         busy,
  output logic [15:0]  frame_count,
  output logic         overflow
);

  logic [FRAME_W-1:0] sample;
  logic [NOTE_W-1:0]  sample_keys;

  key_sync #(.WIDTH(FRAME_W)) u_key_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (pack_frame(keys, shift)),
    .q     (sample)
  );

  assign sample_keys = sample[FRAME_W-1:NOTE_LSB];

  rec_state_t         state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               pending_q, pending_d;
  logic [FRAME_W-1:0] data_q, data_d;
  logic [15:0]        count_q, count_d;
  logic               overflow_q, overflow_d;

  logic xfer;
  logic tick;
  logic full;

  assign xfer = pending_q & wr_ready;
  assign tick = (cnt_q == CNT_W'(PERIOD - 1));
  // A pending frame already owns a buffer slot, so it counts toward capacity.
  assign full = ({1'b0, count_q} + {16'd0, pending_q}) >= 17'(MAX_FRAMES);

  // NOTE: every signal gets a default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    pending_d  = pending_q;
    data_d     = data_q;
    count_d    = count_q;
    overflow_d = overflow_q;

    if (xfer) begin
      pending_d = 1'b0;
      if (count_q != 16'(MAX_FRAMES)) begin
        count_d = count_q + 16'd1;
      end
    end

    case (state_q)
      IDLE: begin
        if (rec_start && !rec_stop) begin
          state_d    = ARMED;
          cnt_d      = '0;
          pending_d  = 1'b0;
          count_d    = '0;
          overflow_d = 1'b0;
        end
      end

      ARMED: begin
        if (rec_stop) begin
          state_d = IDLE;
        end else if (sample_keys != '0) begin
          state_d   = RECORD;
          pending_d = 1'b1;
          data_d    = sample;
          cnt_d     = '0;
        end
      end

      RECORD: begin
        cnt_d = tick ? '0 : cnt_q + CNT_W'(1);
        if (full) begin
          state_d = FLUSH;
        end else begin
          // A transfer on the tick edge frees the slot for the new sample.
          if (tick) begin
            if (!pending_q || xfer) begin
              pending_d = 1'b1;
              data_d    = sample;
            end else begin
              overflow_d = 1'b1;
            end
          end
          if (rec_stop) begin
            state_d = FLUSH;
          end
        end
      end

      FLUSH: begin
        if (!pending_q) begin
          state_d = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      pending_q  <= 1'b0;
      data_q     <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      pending_q  <= pending_d;
      data_q     <= data_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  assign wr_en       = pending_q;
  assign wr_data     = data_q;
  assign busy        = (state_q != IDLE);
  assign frame_count = count_q;
  assign overflow    = overflow_q;

endmodule
